// File: rtl/axi_lite_mem_slave_if.sv
// AXI4-Lite signal bundle between an interconnect port (master) and the
// memory endpoint (slave). Clock and reset are kept outside the bundle.
interface axi_lite_mem_slave_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] AWADDR;
    logic                  AWVALID;
    logic                  AWREADY;
    logic [DATA_WIDTH-1:0] WDATA;
    logic [STRB_WIDTH-1:0] WSTRB;
    logic                  WVALID;
    logic                  WREADY;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RVALID;
    logic                  RREADY;

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite slave backed by a byte-strobed word memory. Independent
// single-outstanding read and write engines; all bus outputs registered.
//
// write engine
//   state         | meaning
//   WR_IDLE       | accepting AW and W
//   WR_HOLD_ADDR  | address captured, waiting for W
//   WR_HOLD_DATA  | data captured, waiting for AW
//   WR_RESP       | write committed, B response offered
// read engine
//   state         | meaning
//   RD_IDLE       | accepting AR
//   RD_RESP       | R response offered
module axi_lite_mem_slave #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 4096
) (
    input logic            ACLK,
    input logic            ARESETn,
    axi_lite_mem_slave_if.slave s_axi
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int LANE_BITS  = (STRB_WIDTH > 1) ? $clog2(STRB_WIDTH) : 0;
    localparam int IDX_W      = ADDR_WIDTH - LANE_BITS;
    localparam int MEM_AW     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [IDX_W:0] DEPTH_LIMIT = MEM_DEPTH[IDX_W:0];
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {WR_IDLE, WR_HOLD_ADDR, WR_HOLD_DATA, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    wr_state_t             wr_state, wr_next;
    logic                  aw_hs, w_hs, b_hs, wr_commit;
    logic [ADDR_WIDTH-1:0] awaddr_q, wr_addr;
    logic [DATA_WIDTH-1:0] wdata_q, wr_data;
    logic [STRB_WIDTH-1:0] wstrb_q, wr_strb;
    logic [IDX_W-1:0]      wr_idx;
    logic                  wr_in_range;

    rd_state_t             rd_state, rd_next;
    logic                  ar_hs, r_hs;
    logic [IDX_W-1:0]      rd_idx;
    logic                  rd_in_range;

    assign aw_hs = s_axi.AWVALID && s_axi.AWREADY;
    assign w_hs  = s_axi.WVALID && s_axi.WREADY;
    assign b_hs  = s_axi.BVALID && s_axi.BREADY;
    assign ar_hs = s_axi.ARVALID && s_axi.ARREADY;
    assign r_hs  = s_axi.RVALID && s_axi.RREADY;

    // Whichever half arrived first comes from its holding register.
    assign wr_addr = (wr_state == WR_HOLD_ADDR) ? awaddr_q : s_axi.AWADDR;
    assign wr_data = (wr_state == WR_HOLD_DATA) ? wdata_q  : s_axi.WDATA;
    assign wr_strb = (wr_state == WR_HOLD_DATA) ? wstrb_q  : s_axi.WSTRB;

    assign wr_idx      = wr_addr[ADDR_WIDTH-1:LANE_BITS];
    assign wr_in_range = {1'b0, wr_idx} < DEPTH_LIMIT;
    assign rd_idx      = s_axi.ARADDR[ADDR_WIDTH-1:LANE_BITS];
    assign rd_in_range = {1'b0, rd_idx} < DEPTH_LIMIT;

    // Write engine next state; commit fires on every entry into WR_RESP.
    always_comb begin
        wr_next   = wr_state;
        wr_commit = 1'b0;
        unique case (wr_state)
            WR_IDLE: begin
                if (aw_hs && w_hs) begin
                    wr_next   = WR_RESP;
                    wr_commit = 1'b1;
                end else if (aw_hs) begin
                    wr_next = WR_HOLD_ADDR;
                end else if (w_hs) begin
                    wr_next = WR_HOLD_DATA;
                end
            end
            WR_HOLD_ADDR: begin
                if (w_hs) begin
                    wr_next   = WR_RESP;
                    wr_commit = 1'b1;
                end
            end
            WR_HOLD_DATA: begin
                if (aw_hs) begin
                    wr_next   = WR_RESP;
                    wr_commit = 1'b1;
                end
            end
            WR_RESP: begin
                if (b_hs) wr_next = WR_IDLE;
            end
            default: wr_next = WR_IDLE;
        endcase
    end

    // Write engine state and registered outputs, decoded from the next state.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_state      <= WR_IDLE;
            s_axi.AWREADY <= 1'b0;
            s_axi.WREADY  <= 1'b0;
            s_axi.BVALID  <= 1'b0;
            s_axi.BRESP   <= RESP_OKAY;
        end else begin
            wr_state      <= wr_next;
            s_axi.AWREADY <= (wr_next == WR_IDLE) || (wr_next == WR_HOLD_DATA);
            s_axi.WREADY  <= (wr_next == WR_IDLE) || (wr_next == WR_HOLD_ADDR);
            s_axi.BVALID  <= (wr_next == WR_RESP);
            if (wr_commit) s_axi.BRESP <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // Holding registers for a half-received write; pure datapath, no reset.
    always_ff @(posedge ACLK) begin
        if (aw_hs) awaddr_q <= s_axi.AWADDR;
        if (w_hs) begin
            wdata_q <= s_axi.WDATA;
            wstrb_q <= s_axi.WSTRB;
        end
    end

    // Memory array: strobed lane writes at commit, in-range only; not reset.
    always_ff @(posedge ACLK) begin
        if (wr_commit && wr_in_range) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (wr_strb[i]) mem[wr_idx[MEM_AW-1:0]][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // Read engine next state.
    always_comb begin
        rd_next = rd_state;
        unique case (rd_state)
            RD_IDLE: if (ar_hs) rd_next = RD_RESP;
            RD_RESP: if (r_hs) rd_next = RD_IDLE;
            default: rd_next = RD_IDLE;
        endcase
    end

    // Read engine state and outputs; RDATA samples the pre-write memory value.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rd_state      <= RD_IDLE;
            s_axi.ARREADY <= 1'b0;
            s_axi.RVALID  <= 1'b0;
            s_axi.RDATA   <= '0;
            s_axi.RRESP   <= RESP_OKAY;
        end else begin
            rd_state      <= rd_next;
            s_axi.ARREADY <= (rd_next == RD_IDLE);
            s_axi.RVALID  <= (rd_next == RD_RESP);
            if (ar_hs) begin
                s_axi.RDATA <= rd_in_range ? mem[rd_idx[MEM_AW-1:0]] : '0;
                s_axi.RRESP <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end
endmodule
